// File: rtl/sw_array_ctrl.sv
// +--------------------------------------------------------------------------+
// | sw_array_ctrl: query preload, array reset, database streaming and result |
// | collection for a linear affine-gap Smith-Waterman systolic array.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sw_array_ctrl #(
  parameter int N_PE        = 48,
  parameter int LOG_N_PE    = 6,
  parameter int SCORE_WIDTH = 11,
  parameter int DB_LEN_W    = 12
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_local,
  input  logic                   i_q_vld,
  input  logic [1:0]             i_q_data,
  output logic                   o_q_rdy,
  input  logic                   i_db_vld,
  input  logic [1:0]             i_db_data,
  input  logic                   i_db_last,
  output logic                   o_db_rdy,
  output logic                   o_pl_shift,
  output logic [1:0]             o_pl_data,
  output logic                   o_arr_rst,
  output logic                   o_arr_vld,
  output logic [1:0]             o_arr_data,
  output logic                   o_arr_local,
  input  logic [SCORE_WIDTH-1:0] i_arr_high,
  output logic                   o_res_vld,
  input  logic                   i_res_rdy,
  output logic [SCORE_WIDTH-1:0] o_res_score,
  output logic [DB_LEN_W-1:0]    o_res_len,
  output logic                   o_res_err,
  output logic                   o_busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_Q  = 3'd1,
    S_ARR_RST = 3'd2,
    S_ARR_GAP = 3'd3,
    S_STREAM  = 3'd4,
    S_DRAIN   = 3'd5,
    S_REPORT  = 3'd6
  } state_t;

  localparam logic [LOG_N_PE-1:0]    c_Q_LAST     = LOG_N_PE'(N_PE - 1);
  localparam logic [LOG_N_PE-1:0]    c_DRAIN_LAST = LOG_N_PE'(N_PE + 1);
  localparam logic [LOG_N_PE-1:0]    c_RST_LAST   = LOG_N_PE'(1);
  localparam logic [DB_LEN_W-1:0]    c_DB_MAX     = '1;
  localparam logic [DB_LEN_W-1:0]    c_DB_PRE     = c_DB_MAX - DB_LEN_W'(1);
  localparam logic [SCORE_WIDTH-1:0] c_BIAS       = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

  state_t                  r_state, w_state_nxt;
  logic [LOG_N_PE-1:0]     r_cnt, w_cnt_nxt;
  logic [DB_LEN_W-1:0]     r_db_cnt, w_db_cnt_nxt;
  logic                    r_err, w_err_nxt;

  logic                    w_q_rdy_nxt, w_db_rdy_nxt, w_pl_shift_nxt;
  logic [1:0]              w_pl_data_nxt, w_arr_data_nxt;
  logic                    w_arr_rst_nxt, w_arr_vld_nxt, w_local_nxt;
  logic                    w_res_vld_nxt, w_res_err_nxt, w_busy_nxt;
  logic [SCORE_WIDTH-1:0]  w_res_score_nxt;
  logic [DB_LEN_W-1:0]     w_res_len_nxt;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_db_cnt_nxt    = r_db_cnt;
    w_err_nxt       = r_err;
    w_local_nxt     = o_arr_local;
    w_q_rdy_nxt     = 1'b0;
    w_db_rdy_nxt    = 1'b0;
    w_pl_shift_nxt  = 1'b0;
    w_pl_data_nxt   = o_pl_data;
    w_arr_rst_nxt   = 1'b0;
    w_arr_vld_nxt   = 1'b0;
    w_arr_data_nxt  = o_arr_data;
    w_res_vld_nxt   = 1'b0;
    w_res_score_nxt = o_res_score;
    w_res_len_nxt   = o_res_len;
    w_res_err_nxt   = o_res_err;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_local_nxt  = i_local;
          w_cnt_nxt    = '0;
          w_db_cnt_nxt = '0;
          w_err_nxt    = 1'b0;
          w_q_rdy_nxt  = 1'b1;
          w_state_nxt  = S_LOAD_Q;
        end
      end

      S_LOAD_Q: begin
        w_q_rdy_nxt = 1'b1;
        if (i_q_vld && o_q_rdy) begin
          w_pl_shift_nxt = 1'b1;
          w_pl_data_nxt  = i_q_data;
          w_cnt_nxt      = r_cnt + LOG_N_PE'(1);
          if (r_cnt == c_Q_LAST) begin
            w_q_rdy_nxt   = 1'b0;
            w_cnt_nxt     = '0;
            w_arr_rst_nxt = 1'b1;
            w_state_nxt   = S_ARR_RST;
          end
        end
      end

      S_ARR_RST: begin
        if (r_cnt == c_RST_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_ARR_GAP;
        end else begin
          w_arr_rst_nxt = 1'b1;
          w_cnt_nxt     = r_cnt + LOG_N_PE'(1);
        end
      end

      S_ARR_GAP: begin
        w_db_rdy_nxt = 1'b1;
        w_state_nxt  = S_STREAM;
      end

      S_STREAM: begin
        w_db_rdy_nxt = 1'b1;
        if (i_db_vld && o_db_rdy) begin
          w_arr_vld_nxt  = 1'b1;
          w_arr_data_nxt = i_db_data;
          if (r_db_cnt != c_DB_MAX) begin
            w_db_cnt_nxt = r_db_cnt + DB_LEN_W'(1);
          end
          // The char that fills the length counter is forced to be the last one.
          if (i_db_last || (r_db_cnt == c_DB_PRE)) begin
            if (!i_db_last) begin
              w_err_nxt = 1'b1;
            end
            w_db_rdy_nxt = 1'b0;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_DRAIN;
          end
        end else if (r_db_cnt != '0) begin
          w_err_nxt = 1'b1;
        end
      end

      S_DRAIN: begin
        if (r_cnt == c_DRAIN_LAST) begin
          w_res_score_nxt = i_arr_high - c_BIAS;
          w_res_len_nxt   = r_db_cnt;
          w_res_err_nxt   = r_err;
          w_res_vld_nxt   = 1'b1;
          w_state_nxt     = S_REPORT;
        end else begin
          w_cnt_nxt = r_cnt + LOG_N_PE'(1);
        end
      end

      S_REPORT: begin
        if (i_res_rdy) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_res_vld_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_db_cnt    <= '0;
      r_err       <= 1'b0;
      o_q_rdy     <= 1'b0;
      o_db_rdy    <= 1'b0;
      o_pl_shift  <= 1'b0;
      o_pl_data   <= '0;
      o_arr_rst   <= 1'b1;
      o_arr_vld   <= 1'b0;
      o_arr_data  <= '0;
      o_arr_local <= 1'b0;
      o_res_vld   <= 1'b0;
      o_res_score <= '0;
      o_res_len   <= '0;
      o_res_err   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_db_cnt    <= w_db_cnt_nxt;
      r_err       <= w_err_nxt;
      o_q_rdy     <= w_q_rdy_nxt;
      o_db_rdy    <= w_db_rdy_nxt;
      o_pl_shift  <= w_pl_shift_nxt;
      o_pl_data   <= w_pl_data_nxt;
      o_arr_rst   <= w_arr_rst_nxt;
      o_arr_vld   <= w_arr_vld_nxt;
      o_arr_data  <= w_arr_data_nxt;
      o_arr_local <= w_local_nxt;
      o_res_vld   <= w_res_vld_nxt;
      o_res_score <= w_res_score_nxt;
      o_res_len   <= w_res_len_nxt;
      o_res_err   <= w_res_err_nxt;
      o_busy      <= w_busy_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sw_array_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_sw_array_ctrl: directed bench with a behavioural PE-array model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sw_array_ctrl;

  localparam int N_PE        = 4;
  localparam int LOG_N_PE    = 3;
  localparam int SCORE_WIDTH = 11;
  localparam int DB_LEN_W    = 3;
  localparam int MATCH = 5, MIS = -4, GO = 8, GE = 2, NEG = -1000;

  logic                   clk = 1'b0;
  logic                   i_rst = 1'b1;
  logic                   i_start = 1'b0, i_local = 1'b0;
  logic                   i_q_vld = 1'b0;
  logic [1:0]             i_q_data = '0;
  logic                   i_db_vld = 1'b0, i_db_last = 1'b0;
  logic [1:0]             i_db_data = '0;
  logic                   i_res_rdy = 1'b1;
  logic [SCORE_WIDTH-1:0] i_arr_high;
  logic                   o_q_rdy, o_db_rdy, o_pl_shift, o_arr_rst, o_arr_vld, o_arr_local;
  logic [1:0]             o_pl_data, o_arr_data;
  logic                   o_res_vld, o_res_err, o_busy;
  logic [SCORE_WIDTH-1:0] o_res_score;
  logic [DB_LEN_W-1:0]    o_res_len;

  sw_array_ctrl #(
    .N_PE(N_PE), .LOG_N_PE(LOG_N_PE), .SCORE_WIDTH(SCORE_WIDTH), .DB_LEN_W(DB_LEN_W)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_local(i_local),
    .i_q_vld(i_q_vld), .i_q_data(i_q_data), .o_q_rdy(o_q_rdy),
    .i_db_vld(i_db_vld), .i_db_data(i_db_data), .i_db_last(i_db_last), .o_db_rdy(o_db_rdy),
    .o_pl_shift(o_pl_shift), .o_pl_data(o_pl_data),
    .o_arr_rst(o_arr_rst), .o_arr_vld(o_arr_vld), .o_arr_data(o_arr_data),
    .o_arr_local(o_arr_local), .i_arr_high(i_arr_high),
    .o_res_vld(o_res_vld), .i_res_rdy(i_res_rdy), .o_res_score(o_res_score),
    .o_res_len(o_res_len), .o_res_err(o_res_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SCORE_WIDTH-1:0] score;
    logic [DB_LEN_W-1:0]    len;
    logic                   err;
  } res_t;

  res_t       exp_res[$];
  logic [1:0] exp_pl[$];
  logic [1:0] exp_arr[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Gotoh alignment; char k of q/d sits at bits [2k+1:2k]. Gap of length k costs GO+GE*(k-1).
  function automatic int sw_score(input logic [7:0] q, input logic [15:0] d, input int n, input bit loc);
    int h[0:4][0:8];
    int e[0:4][0:8];
    int f[0:4][0:8];
    int best, s;
    best = 0;
    for (int j = 0; j <= 8; j++) begin
      h[0][j] = (loc || j == 0) ? 0 : -(GO + GE * (j - 1));
      e[0][j] = NEG;
      f[0][j] = NEG;
    end
    for (int i = 1; i <= 4; i++) begin
      h[i][0] = loc ? 0 : -(GO + GE * (i - 1));
      e[i][0] = NEG;
      f[i][0] = NEG;
      for (int j = 1; j <= 8; j++) begin
        if (j <= n) begin
          e[i][j] = (e[i][j-1] - GE > h[i][j-1] - GO) ? e[i][j-1] - GE : h[i][j-1] - GO;
          f[i][j] = (f[i-1][j] - GE > h[i-1][j] - GO) ? f[i-1][j] - GE : h[i-1][j] - GO;
          s = h[i-1][j-1] + ((q[2*i-2 +: 2] == d[2*j-2 +: 2]) ? MATCH : MIS);
          if (e[i][j] > s) s = e[i][j];
          if (f[i][j] > s) s = f[i][j];
          if (loc && s < 0) s = 0;
          h[i][j] = s;
          if (s > best) best = s;
        end else begin
          h[i][j] = NEG;
          e[i][j] = NEG;
          f[i][j] = NEG;
        end
      end
    end
    return loc ? best : h[4][n];
  endfunction

  // Array model: preload chain, observed database, score delayed by N_PE cycles.
  logic [7:0]             m_pl = '0;
  logic [15:0]            m_db = '0;
  int                     m_n = 0;
  logic [SCORE_WIDTH-1:0] m_cur;
  logic [SCORE_WIDTH-1:0] m_dly[N_PE];

  always_comb begin
    m_cur = '0;
    m_cur = SCORE_WIDTH'(((m_n == 0) ? 0 :
            sw_score({m_pl[1:0], m_pl[3:2], m_pl[5:4], m_pl[7:6]}, m_db, m_n, o_arr_local)) + 1024);
  end

  always @(posedge clk) begin
    if (o_pl_shift) m_pl <= {m_pl[5:0], o_pl_data};
    if (o_arr_rst) m_n <= 0;
    else if (o_arr_vld && m_n < 8) begin
      m_db[2*m_n +: 2] <= o_arr_data;
      m_n              <= m_n + 1;
    end
    m_dly[0] <= m_cur;
    for (int k = 1; k < N_PE; k++) m_dly[k] <= m_dly[k-1];
  end
  assign i_arr_high = m_dly[N_PE-1];

  int rst_run = 0;
  always @(negedge clk) begin
    if (o_pl_shift) begin
      chk("pl_avail", exp_pl.size() != 0, 1);
      if (exp_pl.size() != 0) chk("pl_data", o_pl_data, exp_pl.pop_front());
    end
    if (o_arr_vld) begin
      chk("arr_avail", exp_arr.size() != 0, 1);
      if (exp_arr.size() != 0) chk("arr_data", o_arr_data, exp_arr.pop_front());
    end
    if (o_res_vld && i_res_rdy) begin
      chk("res_avail", exp_res.size() != 0, 1);
      if (exp_res.size() != 0) begin
        chk("res_score", o_res_score, exp_res[0].score);
        chk("res_len", o_res_len, exp_res[0].len);
        chk("res_err", o_res_err, exp_res[0].err);
        exp_res.delete(0);
      end
    end
    if (o_arr_rst && o_busy) rst_run <= rst_run + 1;
    else if (rst_run != 0) begin
      chk("arr_rst_len", rst_run, 2);
      rst_run <= 0;
    end
  end

  task automatic start_job(input bit loc);
    @(negedge clk);
    i_start = 1'b1;
    i_local = loc;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_start", o_busy, 1);
    chk("local_latch", o_arr_local, loc);
  endtask

  task automatic q_send(input logic [1:0] c);
    int n = 0;
    @(negedge clk);
    i_q_vld  = 1'b1;
    i_q_data = c;
    while (!o_q_rdy && n < 20) begin @(negedge clk); n++; end
    chk("q_rdy_wait", o_q_rdy, 1);
    if (o_q_rdy) begin
      exp_pl.push_back(c);
      @(posedge clk); #1;
    end
    i_q_vld = 1'b0;
  endtask

  task automatic db_send(input logic [1:0] c, input bit last, input int bound, output bit acc);
    int n = 0;
    @(negedge clk);
    i_db_vld  = 1'b1;
    i_db_data = c;
    i_db_last = last;
    while (!o_db_rdy && n < bound) begin @(negedge clk); n++; end
    acc = o_db_rdy;
    if (acc) begin
      exp_arr.push_back(c);
      @(posedge clk); #1;
    end
    i_db_vld  = 1'b0;
    i_db_last = 1'b0;
  endtask

  task automatic run_job(input logic [7:0] q, input logic [15:0] d, input int dn,
                         input bit loc, input int bubble_at, input bit poke);
    res_t e;
    bit   acc;
    e.score = SCORE_WIDTH'(sw_score(q, d, dn, loc));
    e.len   = DB_LEN_W'(dn);
    e.err   = (bubble_at > 0);
    exp_res.push_back(e);
    start_job(loc);
    for (int k = 0; k < N_PE; k++) q_send(q[2*k +: 2]);
    if (poke) i_start = 1'b1;
    for (int k = 0; k < dn; k++) begin
      if (k == bubble_at) begin @(posedge clk); #1; end
      db_send(d[2*k +: 2], k == dn - 1, 20, acc);
      chk("db_rdy_wait", acc, 1);
    end
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_res.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("res_pending", exp_res.size(), 0);
    exp_res.delete();
    chk("idle_after", o_busy, 0);
    chk("res_vld_drop", o_res_vld, 0);
  endtask

  logic [19:0] dd;
  int          acc_n;
  bit          acc;
  int          n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arr_rst", o_arr_rst, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_q_rdy", o_q_rdy, 0);
    chk("rst_db_rdy", o_db_rdy, 0);
    chk("rst_res_vld", o_res_vld, 0);
    chk("rst_pl_shift", o_pl_shift, 0);
    chk("rst_arr_vld", o_arr_vld, 0);
    chk("rst_score", o_res_score, 0);
    i_rst = 1'b0;
    chk("rst_tail", o_arr_rst, 1);
    @(posedge clk); #1;
    chk("rst_release", o_arr_rst, 0);

    run_job(8'hE4, 16'h00E4, 4, 1'b1, -1, 1'b0);   // AGTC vs AGTC local
    wait_done();
    run_job(8'h00, 16'h00FF, 4, 1'b1, -1, 1'b0);   // AAAA vs CCCC local
    wait_done();
    run_job(8'hE4, 16'h00E4, 4, 1'b1, 2, 1'b0);    // bubble between chars 2 and 3
    wait_done();
    run_job(8'hE4, 16'h0034, 3, 1'b0, -1, 1'b0);   // AGTC vs AGC global
    wait_done();
    run_job(8'h00, 16'h000F, 2, 1'b0, -1, 1'b0);   // AAAA vs CC global, negative
    wait_done();

    // Result held under back-pressure; start pulses must not disturb the job.
    i_res_rdy = 1'b0;
    run_job(8'hE4, 16'h00E4, 4, 1'b1, -1, 1'b1);
    n = 0;
    while (!o_res_vld && n < 200) begin @(negedge clk); n++; end
    chk("hold_reach", o_res_vld, 1);
    for (int k = 0; k < 10; k++) begin
      i_start = (k >= 3 && k < 6);
      @(negedge clk);
      chk("hold_vld", o_res_vld, 1);
      chk("hold_score", o_res_score, exp_res[0].score);
      chk("hold_busy", o_busy, 1);
    end
    i_start = 1'b0;
    @(posedge clk); #1;
    i_res_rdy = 1'b1;
    wait_done();
    repeat (5) @(negedge clk);
    chk("start_ignored", o_busy, 0);

    // Abort mid-stream after two chars.
    start_job(1'b1);
    for (int k = 0; k < N_PE; k++) q_send(2'(k));
    for (int k = 0; k < 2; k++) db_send(2'(k), 1'b0, 20, acc);
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    chk("abort_idle", o_busy, 0);
    chk("abort_db_rdy", o_db_rdy, 0);
    chk("abort_arr_rst", o_arr_rst, 1);
    chk("abort_res_vld", o_res_vld, 0);
    repeat (10) @(negedge clk);
    chk("abort_no_job", o_busy, 0);
    run_job(8'hE4, 16'h00E4, 4, 1'b1, -1, 1'b0);
    wait_done();

    // Ten chars without last against a 3-bit length counter.
    for (int k = 0; k < 10; k++) dd[2*k +: 2] = 2'(k % 4);
    begin
      res_t e;
      e.score = SCORE_WIDTH'(sw_score(8'hE4, dd[15:0], 7, 1'b1));
      e.len   = DB_LEN_W'(7);
      e.err   = 1'b1;
      exp_res.push_back(e);
    end
    start_job(1'b1);
    for (int k = 0; k < N_PE; k++) q_send(8'hE4 >> (2 * k));
    acc_n = 0;
    for (int k = 0; k < 10; k++) begin
      db_send(dd[2*k +: 2], 1'b0, 3, acc);
      if (!acc) break;
      acc_n++;
    end
    chk("ovf_accepted", acc_n, 7);
    wait_done();

    repeat (3) @(negedge clk);
    chk("pl_left", exp_pl.size(), 0);
    chk("arr_left", exp_arr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
